// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan multiplexer.
//   SEG_OFF           - active-low "all segments off" pattern (dp included)
//   IDLE/BLANK/SHOW   - 2-bit FSM state encodings
//   clog2()           - counter width helper, never returns less than 1
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    // Bits needed to hold values 0..value-1. The minimum is 1 so a
    // 1-entry range still gets a real register.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: position counter for the digit scan.
//   clk, rst        - clock, asynchronous active-high reset
//   clear_i         - next edge: cnt=0, idx=0 (takes priority)
//   advance_i       - next edge: step cnt; at slot end cnt=0 and idx steps
//   slot_end_o      - current cnt is the last cycle of the slot
//   frame_wrap_o    - current idx is the last digit of the frame
//   blank_active_o  - slot position after the coming edge lies in the gap
//   idx_next_o      - digit index after the coming edge
// blank_active_o and idx_next_o look one edge ahead so the top level can
// register outputs that already match the new counter values.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int CNT_W = clog2(CLK_DIV),
    localparam int IDX_W = clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic             slot_end_o,
    output logic             frame_wrap_o,
    output logic             blank_active_o,
    output logic [IDX_W-1:0] idx_next_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign slot_end_o   = (cnt_q == CNT_LAST);
    assign frame_wrap_o = (idx_q == IDX_LAST);

    // Both counters wrap explicitly; CLK_DIV and NUM_DIGITS need not be
    // powers of two.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (advance_i) begin
            if (slot_end_o) begin
                cnt_d = '0;
                idx_d = frame_wrap_o ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign blank_active_o = (cnt_d < CNT_BLANK);
    assign idx_next_o     = idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes NUM_DIGITS active-low segment patterns
// onto one shared segment bus with active-low anode enables.
//   clk, rst    - clock, asynchronous active-high reset
//   enable      - scan enable; low keeps the display dark
//   seg_in      - digit k pattern in bits [8k+7:8k], digit 0 rightmost
//   seg_out     - active-low segment bus, bit 7 = dp
//   an_out      - active-low digit enables, at most one low
//   frame_tick  - one-cycle pulse on every frame-start edge
// Each slot is BLANK_CYCLES dark cycles followed by CLK_DIV-BLANK_CYCLES
// lit cycles. Patterns are captured only at frame start so a digit never
// changes mid-frame. Requires 1 <= BLANK_CYCLES < CLK_DIV.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int IDX_W = clog2(NUM_DIGITS);

    logic [1:0]              state_q, state_d;
    logic                    running, clear, frame_start;
    logic                    slot_end, frame_wrap, blank_active;
    logic [IDX_W-1:0]        idx_next;
    logic [8*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [7:0]              digit_d [NUM_DIGITS];
    logic [7:0]              seg_d, seg_q;
    logic [NUM_DIGITS-1:0]   an_d, an_q;
    logic                    tick_q;

    seg7_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .CLK_DIV     (CLK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear),
        .advance_i     (!clear),
        .slot_end_o    (slot_end),
        .frame_wrap_o  (frame_wrap),
        .blank_active_o(blank_active),
        .idx_next_o    (idx_next)
    );

    // Any state other than BLANK/SHOW (including unused encodings) is
    // treated as idle, so the counters are held cleared there and a
    // rising enable always restarts at digit 0.
    assign running = (state_q == BLANK) || (state_q == SHOW);
    assign clear   = !enable || !running;

    // A frame starts when a scan begins from idle or the last digit's
    // slot ends while still enabled.
    assign frame_start = enable &&
                         (!running || ((state_q == SHOW) && slot_end && frame_wrap));

    // The gap/lit decision comes straight from the next slot position.
    assign state_d = !enable ? IDLE : (blank_active ? BLANK : SHOW);

    assign shadow_d = frame_start ? seg_in : shadow_q;

    // Outputs are computed from the post-edge state, index and shadow so
    // they line up with the registers updated on the same edge.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_d[gi] = shadow_d[8*gi +: 8];
        assign an_d[gi]    = !((state_d == SHOW) && (idx_next == IDX_W'(gi)));
    end

    always_comb begin
        seg_d = SEG_OFF;
        if (state_d == SHOW) begin
            seg_d = digit_d[idx_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= {NUM_DIGITS{SEG_OFF}};
            seg_q    <= SEG_OFF;
            an_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= frame_start;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_tick = tick_q;

endmodule
